// File: rtl/lotr_pkg.sv
// rtl/lotr_pkg.sv - shared memory request types, latency limits and init FSM states
//
// Purpose : common definitions for the dual-port byte-enable memory family.
// Contents: t_mem_req request bundle (sized by the LOTR_MEM_* constants),
//           RD_LAT_MAX, and the t_mem_init_st init FSM state encoding.

package lotr_pkg;

   localparam int LOTR_MEM_DATA_W = 32;
   localparam int LOTR_MEM_BE_W   = LOTR_MEM_DATA_W / 8;
   localparam int LOTR_MEM_ADDR_W = 10;

   // Deepest read pipeline a memory port may be built with.
   localparam int RD_LAT_MAX = 2;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } t_mem_init_st;

   typedef struct packed {
      logic [LOTR_MEM_ADDR_W-1:0] addr;
      logic [LOTR_MEM_DATA_W-1:0] data;
      logic [LOTR_MEM_BE_W-1:0]   be;
      logic                       rden;
      logic                       wren;
   } t_mem_req;

endpackage

// File: rtl/dp_mem_rd_pipe.sv
// rtl/dp_mem_rd_pipe.sv - per-port read data/valid pipeline of depth RD_LAT
//
// Purpose : registers the read word and its valid flag for RD_LAT cycles.
//           Idle cycles load zero so stale data never lingers on q.
// Ports   : clock, rst       - clock and synchronous active-high flush
//           in_valid/in_data - read launched this cycle and its word
//           q/qvalid         - read word and valid at the pipeline tail

module dp_mem_rd_pipe
   import lotr_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] q,
   output logic              qvalid
);

   // Out-of-range latencies clamp to the nearest supported depth.
   localparam int LAT = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : 1;

   logic [DATA_W-1:0] s1_data;
   logic              s1_valid;

   always_ff @(posedge clock) begin
      if (rst) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_data  <= in_valid ? in_data : '0;
         s1_valid <= in_valid;
      end
   end

   generate
      if (LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] s2_data;
         logic              s2_valid;

         always_ff @(posedge clock) begin
            if (rst) begin
               s2_data  <= '0;
               s2_valid <= 1'b0;
            end else begin
               s2_data  <= s1_data;
               s2_valid <= s1_valid;
            end
         end

         assign q      = s2_data;
         assign qvalid = s2_valid;
      end else begin : g_lat1
         assign q      = s1_data;
         assign qvalid = s1_valid;
      end
   endgenerate

endmodule

// File: rtl/dp_mem_be.sv
// rtl/dp_mem_be.sv - true dual-port memory with byte enables, zero-fill init and collision flag
//
// Purpose : DEPTH x DATA_W array shared by a core port (A) and a ring port (B).
//           After reset an init FSM zero-fills every word, one per cycle.
//           Same-address writes merge per byte with port B winning overlaps.
// Ports   : clock, rst                 - clock, synchronous active-high reset
//           init_busy                  - array is being zero-filled
//           addr_x/data_x/be_x         - word address, write data, byte enables
//           rden_x/wren_x              - read / write request
//           q_x/qvalid_x               - read data and valid, RD_LAT cycles later
//           collision                  - pulse: overlapping same-address writes

module dp_mem_be
   import lotr_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int BE_W        = DATA_W / 8,
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int RD_LAT      = 1,
   parameter int RDW_MODE    = 0,
   parameter int INIT_ON_RST = 1
) (
   input  logic              clock,
   input  logic              rst,
   output logic              init_busy,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] data_a,
   input  logic [BE_W-1:0]   be_a,
   input  logic              rden_a,
   input  logic              wren_a,
   output logic [DATA_W-1:0] q_a,
   output logic              qvalid_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_b,
   input  logic [BE_W-1:0]   be_b,
   input  logic              rden_b,
   input  logic              wren_b,
   output logic [DATA_W-1:0] q_b,
   output logic              qvalid_b,
   output logic              collision
);

   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   t_mem_init_st      state_q, state_d;
   logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
   logic              ready;

   logic              addr_ok_a, addr_ok_b;
   logic [ADDR_W-1:0] idx_a, idx_b;
   logic              wr_en_a, wr_en_b, rd_go_a, rd_go_b, same_addr;
   logic [DATA_W-1:0] old_a, old_b, merge_a, merge_b;
   logic [DATA_W-1:0] rd_data_a, rd_data_b;

   // ---------------- init FSM ----------------
   always_ff @(posedge clock) begin
      if (rst) begin
         if (INIT_ON_RST != 0) state_q <= INIT;
         else                  state_q <= READY;
         init_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      if (state_q == INIT) begin
         if (init_ptr_q == LAST_PTR) begin
            state_d    = READY;
            init_ptr_d = '0;
         end else begin
            init_ptr_d = init_ptr_q + 1'b1;
         end
      end
   end

   always_comb begin
      init_busy = (state_q == INIT);
      ready     = (state_q == READY);
   end

   // ---------------- request qualification ----------------
   assign addr_ok_a = {1'b0, addr_a} < DEPTH_LIM;
   assign addr_ok_b = {1'b0, addr_b} < DEPTH_LIM;
   // Out-of-range requests still index a legal word; their results are masked.
   assign idx_a     = addr_ok_a ? addr_a : '0;
   assign idx_b     = addr_ok_b ? addr_b : '0;
   assign wr_en_a   = ready & wren_a & addr_ok_a;
   assign wr_en_b   = ready & wren_b & addr_ok_b;
   assign rd_go_a   = ready & rden_a;
   assign rd_go_b   = ready & rden_b;
   assign same_addr = (addr_a == addr_b);

   // Post-write image of the word at each port's address. It serves both as
   // the value to store and as the new-data read result, so the B-wins rule
   // is applied in exactly one place.
   always_comb begin
      old_a   = mem[idx_a];
      old_b   = mem[idx_b];
      merge_a = old_a;
      merge_b = old_b;
      for (int i = 0; i < BE_W; i++) begin
         if (wr_en_b && same_addr && be_b[i])
            merge_a[8*i +: 8] = data_b[8*i +: 8];
         else if (wr_en_a && be_a[i])
            merge_a[8*i +: 8] = data_a[8*i +: 8];

         if (wr_en_b && be_b[i])
            merge_b[8*i +: 8] = data_b[8*i +: 8];
         else if (wr_en_a && same_addr && be_a[i])
            merge_b[8*i +: 8] = data_a[8*i +: 8];
      end
   end

   // ---------------- storage ----------------
   // With both ports on one address merge_a equals merge_b, so the order of
   // the two stores does not matter.
   always_ff @(posedge clock) begin
      if (!rst) begin
         if (init_busy) begin
            mem[init_ptr_q] <= '0;
         end else begin
            if (wr_en_a) mem[idx_a] <= merge_a;
            if (wr_en_b) mem[idx_b] <= merge_b;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) collision <= 1'b0;
      else     collision <= wr_en_a & wr_en_b & same_addr & (|(be_a & be_b));
   end

   // ---------------- read path ----------------
   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      if (rd_go_a && addr_ok_a) rd_data_a = (RDW_MODE != 0) ? merge_a : old_a;
      if (rd_go_b && addr_ok_b) rd_data_b = (RDW_MODE != 0) ? merge_b : old_b;
   end

   dp_mem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe_a (
      .clock    (clock),
      .rst      (rst),
      .in_valid (rd_go_a),
      .in_data  (rd_data_a),
      .q        (q_a),
      .qvalid   (qvalid_a)
   );

   dp_mem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe_b (
      .clock    (clock),
      .rst      (rst),
      .in_valid (rd_go_b),
      .in_data  (rd_data_b),
      .q        (q_b),
      .qvalid   (qvalid_b)
   );

endmodule

// File: tb/tb_dp_mem_be.sv
// tb/tb_dp_mem_be.sv - directed self-checking bench for dp_mem_be
//
// Two instances share every input: d16 (DEPTH 16, RD_LAT 1, old-data RDW)
// and d12 (DEPTH 12, RD_LAT 2, new-data RDW).

module tb_dp_mem_be;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst;
   logic [3:0]  addr_a, addr_b, be_a, be_b;
   logic [31:0] data_a, data_b;
   logic        rden_a, wren_a, rden_b, wren_b;

   logic        busy16, qva16, qvb16, col16;
   logic [31:0] qa16, qb16;
   logic        busy12, qva12, qvb12, col12;
   logic [31:0] qa12, qb12;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] exp_mem [16];

   dp_mem_be #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0), .INIT_ON_RST(1)) u_d16 (
      .clock(clock), .rst(rst), .init_busy(busy16),
      .addr_a(addr_a), .data_a(data_a), .be_a(be_a), .rden_a(rden_a), .wren_a(wren_a),
      .q_a(qa16), .qvalid_a(qva16),
      .addr_b(addr_b), .data_b(data_b), .be_b(be_b), .rden_b(rden_b), .wren_b(wren_b),
      .q_b(qb16), .qvalid_b(qvb16), .collision(col16)
   );

   dp_mem_be #(.DATA_W(32), .DEPTH(12), .RD_LAT(2), .RDW_MODE(1), .INIT_ON_RST(1)) u_d12 (
      .clock(clock), .rst(rst), .init_busy(busy12),
      .addr_a(addr_a), .data_a(data_a), .be_a(be_a), .rden_a(rden_a), .wren_a(wren_a),
      .q_a(qa12), .qvalid_a(qva12),
      .addr_b(addr_b), .data_b(data_b), .be_b(be_b), .rden_b(rden_b), .wren_b(wren_b),
      .q_b(qb12), .qvalid_b(qvb12), .collision(col12)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle;
      rden_a = 1'b0; wren_a = 1'b0; addr_a = '0; data_a = '0; be_a = '0;
      rden_b = 1'b0; wren_b = 1'b0; addr_b = '0; data_b = '0; be_b = '0;
   endtask

   task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      idle;
      wren_a = 1'b1; addr_a = a; data_a = d; be_a = be;
      tick;
      idle;
   endtask

   task automatic count_busy(output int c16, output int c12);
      c16 = 0;
      c12 = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (busy16 === 1'b1) c16++;
         if (busy12 === 1'b1) c12++;
         tick;
      end
   endtask

   task automatic test_reset;
      idle;
      rst = 1'b1;
      tick;
      tick;
      @(negedge clock);
      vectors++;
      if ({qa16, qva16, qb16, qvb16, col16} !== 67'd0) begin
         errors++;
         $display("FAIL reset_outs_d16: got %h want 0", {qa16, qva16, qb16, qvb16, col16});
      end
      vectors++;
      if ({qa12, qva12, qb12, qvb12, col12} !== 67'd0) begin
         errors++;
         $display("FAIL reset_outs_d12: got %h want 0", {qa12, qva12, qb12, qvb12, col12});
      end
      tick;
      rst = 1'b0;
      @(negedge clock);
      vectors++;
      if ({busy16, busy12} !== 2'b11) begin
         errors++;
         $display("FAIL reset_busy: got %b want 11", {busy16, busy12});
      end
      tick;
      for (int n = 0; n < 40 && (busy16 !== 1'b0 || busy12 !== 1'b0); n++) tick;
      vectors++;
      if ({busy16, busy12} !== 2'b00) begin
         errors++;
         $display("FAIL init_timeout: busy %b want 00", {busy16, busy12});
      end
   endtask

   task automatic test_init;
      int c16, c12;
      for (int i = 0; i < 16; i++) wr_a(4'(i), 32'h0101_0101 * (i + 1), 4'hF);
      rden_a = 1'b1; addr_a = 4'd5;
      tick;
      idle;
      @(negedge clock);
      vectors++;
      if (qa16 !== 32'h0606_0606 || qva16 !== 1'b1) begin
         errors++;
         $display("FAIL preload_d16: got %h/%b want 06060606/1", qa16, qva16);
      end
      vectors++;
      if (qva12 !== 1'b0) begin
         errors++;
         $display("FAIL lat2_early_d12: qvalid %b want 0", qva12);
      end
      tick;
      @(negedge clock);
      vectors++;
      if (qa12 !== 32'h0606_0606 || qva12 !== 1'b1) begin
         errors++;
         $display("FAIL preload_d12: got %h/%b want 06060606/1", qa12, qva12);
      end
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      count_busy(c16, c12);
      vectors++;
      if (c16 != 16) begin
         errors++;
         $display("FAIL init_cycles_d16: got %0d want 16", c16);
      end
      vectors++;
      if (c12 != 12) begin
         errors++;
         $display("FAIL init_cycles_d12: got %0d want 12", c12);
      end
      for (int i = 0; i < 16; i++) begin
         exp_mem[i] = '0;
         rden_a = 1'b1; addr_a = 4'(i);
         tick;
         idle;
         @(negedge clock);
         vectors++;
         if (qa16 !== 32'h0 || qva16 !== 1'b1) begin
            errors++;
            $display("FAIL zero_fill_d16[%0d]: got %h/%b want 0/1", i, qa16, qva16);
         end
         tick;
         @(negedge clock);
         vectors++;
         if (qa12 !== 32'h0 || qva12 !== 1'b1) begin
            errors++;
            $display("FAIL zero_fill_d12[%0d]: got %h/%b want 0/1", i, qa12, qva12);
         end
         tick;
      end
   endtask

   task automatic test_init_restart;
      int c16, c12;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      repeat (7) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      count_busy(c16, c12);
      vectors++;
      if (c16 != 16) begin
         errors++;
         $display("FAIL restart_cycles_d16: got %0d want 16", c16);
      end
      vectors++;
      if (c12 != 12) begin
         errors++;
         $display("FAIL restart_cycles_d12: got %0d want 12", c12);
      end
   endtask

   task automatic test_byte_enable;
      wr_a(4'd5, 32'h1122_3344, 4'hF);
      wr_a(4'd5, 32'hDEAD_BEEF, 4'b0101);
      exp_mem[5] = 32'h11AD_33EF;
      rden_a = 1'b1; addr_a = 4'd5;
      tick;
      idle;
      @(negedge clock);
      vectors++;
      if (qa16 !== 32'h11AD_33EF || qva16 !== 1'b1) begin
         errors++;
         $display("FAIL be_merge_d16: got %h/%b want 11ad33ef/1", qa16, qva16);
      end
      tick;
      @(negedge clock);
      vectors++;
      if (qa12 !== 32'h11AD_33EF || qva12 !== 1'b1) begin
         errors++;
         $display("FAIL be_merge_d12: got %h/%b want 11ad33ef/1", qa12, qva12);
      end
      tick;
   endtask

   task automatic test_collision;
      idle;
      wren_a = 1'b1; addr_a = 4'd3; data_a = 32'hAAAA_AAAA; be_a = 4'hF;
      wren_b = 1'b1; addr_b = 4'd3; data_b = 32'hBBBB_BBBB; be_b = 4'b0011;
      tick;
      idle;
      exp_mem[3] = 32'hAAAA_BBBB;
      @(negedge clock);
      vectors++;
      if ({col16, col12} !== 2'b11) begin
         errors++;
         $display("FAIL collision_pulse: got %b want 11", {col16, col12});
      end
      tick;
      @(negedge clock);
      vectors++;
      if ({col16, col12} !== 2'b00) begin
         errors++;
         $display("FAIL collision_one_cycle: got %b want 00", {col16, col12});
      end
      tick;
      wren_a = 1'b1; addr_a = 4'd4; data_a = 32'hCCCC_CCCC; be_a = 4'b1100;
      wren_b = 1'b1; addr_b = 4'd4; data_b = 32'hDDDD_DDDD; be_b = 4'b0011;
      tick;
      idle;
      exp_mem[4] = 32'hCCCC_DDDD;
      @(negedge clock);
      vectors++;
      if ({col16, col12} !== 2'b00) begin
         errors++;
         $display("FAIL collision_disjoint_be: got %b want 00", {col16, col12});
      end
      tick;
      rden_b = 1'b1; addr_b = 4'd3;
      tick;
      idle;
      @(negedge clock);
      vectors++;
      if (qb16 !== 32'hAAAA_BBBB) begin
         errors++;
         $display("FAIL b_wins_d16: got %h want aaaabbbb", qb16);
      end
      tick;
      @(negedge clock);
      vectors++;
      if (qb12 !== 32'hAAAA_BBBB) begin
         errors++;
         $display("FAIL b_wins_d12: got %h want aaaabbbb", qb12);
      end
      tick;
   endtask

   task automatic test_rdw;
      wren_a = 1'b1; addr_a = 4'd9; data_a = 32'h1234_5678; be_a = 4'hF;
      rden_b = 1'b1; addr_b = 4'd9;
      tick;
      idle;
      @(negedge clock);
      vectors++;
      if (qb16 !== 32'h0 || qvb16 !== 1'b1) begin
         errors++;
         $display("FAIL rdw_old_d16: got %h/%b want 0/1", qb16, qvb16);
      end
      tick;
      @(negedge clock);
      vectors++;
      if (qb12 !== 32'h1234_5678 || qvb12 !== 1'b1) begin
         errors++;
         $display("FAIL rdw_new_d12: got %h/%b want 12345678/1", qb12, qvb12);
      end
      tick;
      wren_a = 1'b1; rden_a = 1'b1; addr_a = 4'd9; data_a = 32'hFFFF_FFFF; be_a = 4'b0001;
      wren_b = 1'b1; addr_b = 4'd9; data_b = 32'h0000_AA00; be_b = 4'b0011;
      tick;
      idle;
      exp_mem[9] = 32'h1234_AA00;
      @(negedge clock);
      vectors++;
      if (qa16 !== 32'h1234_5678 || col16 !== 1'b1) begin
         errors++;
         $display("FAIL rdw_merge_old_d16: got %h col %b want 12345678 col 1", qa16, col16);
      end
      tick;
      @(negedge clock);
      vectors++;
      if (qa12 !== 32'h1234_AA00) begin
         errors++;
         $display("FAIL rdw_merge_new_d12: got %h want 1234aa00", qa12);
      end
      tick;
   endtask

   task automatic test_out_of_range;
      wr_a(4'd13, 32'h5A5A_5A5A, 4'hF);
      exp_mem[13] = 32'h5A5A_5A5A;
      rden_a = 1'b1; addr_a = 4'd13;
      tick;
      idle;
      @(negedge clock);
      vectors++;
      if (qa16 !== 32'h5A5A_5A5A || qva16 !== 1'b1) begin
         errors++;
         $display("FAIL addr13_d16: got %h/%b want 5a5a5a5a/1", qa16, qva16);
      end
      tick;
      @(negedge clock);
      vectors++;
      if (qa12 !== 32'h0 || qva12 !== 1'b1) begin
         errors++;
         $display("FAIL addr13_oor_d12: got %h/%b want 0/1", qa12, qva12);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      for (int c = 0; c < 14; c++) begin
         if (c < 12) begin
            rden_b = 1'b1; addr_b = 4'(c);
         end else begin
            rden_b = 1'b0; addr_b = '0;
         end
         @(negedge clock);
         if (c >= 1 && c <= 12) begin
            vectors++;
            if (qb16 !== exp_mem[c-1] || qvb16 !== 1'b1) begin
               errors++;
               $display("FAIL b2b_d16[%0d]: got %h/%b want %h/1", c - 1, qb16, qvb16, exp_mem[c-1]);
            end
         end
         if (c >= 2) begin
            vectors++;
            if (qb12 !== exp_mem[c-2] || qvb12 !== 1'b1) begin
               errors++;
               $display("FAIL b2b_d12[%0d]: got %h/%b want %h/1", c - 2, qb12, qvb12, exp_mem[c-2]);
            end
         end
         tick;
      end
      idle;
   endtask

   initial begin
      test_reset;
      test_init;
      test_init_restart;
      test_byte_enable;
      test_collision;
      test_rdw;
      test_out_of_range;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
